// File: rtl/run_match_arbiter_pkg.sv
// Shared types for the run-match arbiter: the two-state scheduler encoding.
package run_match_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/run_match_counter.sv
// Equal-run counter: counts consecutive e=1 samples and flags the sample that
// completes a run of RUN_LEN.
module run_match_counter #(
  parameter int RUN_LEN = 4
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clr,
  input  logic e,
  output logic hit
);

  localparam int CW = $clog2(RUN_LEN + 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (clr || !e) begin
      cnt <= '0;
    end else if (cnt != CW'(RUN_LEN)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = e && (cnt == CW'(RUN_LEN - 1));

endmodule

// File: rtl/run_match_arbiter.sv
// Round-robin arbiter sharing one run-length equality detector among N channels;
// reports match (done) or timeout for the granted channel, then rotates.
module run_match_arbiter
  import run_match_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int RUN_LEN = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         w1,
  input  logic [N-1:0]         w2,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [$clog2(N)-1:0] done_id
);

  localparam int PW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic [TW-1:0] timer;
  logic          found;
  logic          e;
  logic          hit;
  logic          grant_now;
  logic          timer_end;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign e         = ~(w1[g] ^ w2[g]);
  assign grant_now = (state == IDLE) && (|req);
  assign timer_end = (timer == TW'(TIMEOUT - 1));
  assign busy      = (state == RUN);

  run_match_counter #(.RUN_LEN(RUN_LEN)) u_counter (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (grant_now),
    .e      (e),
    .hit    (hit)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      gnt     <= '0;
      g       <= '0;
      ptr     <= '0;
      timer   <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      done_id <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_now) begin
            gnt   <= {{(N-1){1'b0}}, 1'b1} << pick;
            g     <= pick;
            ptr   <= (pick == PW'(N - 1)) ? '0 : pick + 1'b1;
            timer <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          timer <= timer + 1'b1;
          // A dropped request releases silently and outranks a same-edge match.
          if (!req[g]) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (hit) begin
            done    <= 1'b1;
            done_id <= g;
            gnt     <= '0;
            state   <= IDLE;
          end else if (timer_end) begin
            timeout <= 1'b1;
            done_id <= g;
            gnt     <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_match_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural reference of the round-robin run-match scheduler.
module tb_run_match_arbiter;

  localparam int N       = 4;
  localparam int RUN_LEN = 4;
  localparam int TIMEOUT = 16;

  logic                 Clock = 1'b0;
  logic                 Resetn;
  logic [N-1:0]         req, w1, w2, gnt;
  logic                 busy, done, timeout;
  logic [$clog2(N)-1:0] done_id;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: plain integers describing the scheduler.
  bit m_run, m_done, m_to;
  int m_g, m_ptr, m_cnt, m_tmr, m_id;

  run_match_arbiter #(.N(N), .RUN_LEN(RUN_LEN), .TIMEOUT(TIMEOUT)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .req     (req),
    .w1      (w1),
    .w2      (w2),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .done_id (done_id)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_to = 0;
    m_g = 0; m_ptr = 0; m_cnt = 0; m_tmr = 0; m_id = 0;
  endtask

  // Advance the reference by one edge using the inputs present at that edge.
  task automatic model_step();
    bit eq;
    bit found;
    m_done = 0;
    m_to   = 0;
    if (!m_run) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1;
          m_g   = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_run = 1;
        m_ptr = (m_g + 1) % N;
        m_cnt = 0;
        m_tmr = 0;
      end
    end else begin
      eq = (w1[m_g] == w2[m_g]);
      if (!req[m_g]) begin
        m_run = 0;
      end else if (eq && m_cnt == RUN_LEN - 1) begin
        m_run = 0; m_done = 1; m_id = m_g;
      end else if (m_tmr == TIMEOUT - 1) begin
        m_run = 0; m_to = 1; m_id = m_g;
      end else begin
        m_cnt = eq ? ((m_cnt + 1 > RUN_LEN) ? RUN_LEN : m_cnt + 1) : 0;
        m_tmr = m_tmr + 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
    check("gnt",     32'(gnt),     m_run ? (32'd1 << m_g) : 32'd0);
    check("busy",    32'(busy),    32'(m_run));
    check("done",    32'(done),    32'(m_done));
    check("timeout", 32'(timeout), 32'(m_to));
    check("done_id", 32'(done_id), 32'(m_id));
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    req = '0; w1 = '0; w2 = '0;
    #1;
    model_reset();
    check("rst_gnt",  32'(gnt),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_to",   32'(timeout), 32'd0);
    check("rst_id",   32'(done_id), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seq [5];
    logic [N-1:0] flip;
    int           pat [8];
    int           rate;

    Resetn = 1'b0;
    req = '0; w1 = '0; w2 = '0;

    // Lone requester, steady equal pair: done exactly RUN_LEN edges after grant.
    do_reset();
    req = 4'b0001; w1 = 4'b0001; w2 = 4'b0001;
    tick();
    check("t1_gnt", 32'(gnt), 32'd1);
    for (int i = 0; i < RUN_LEN - 1; i++) begin
      tick();
      check("t1_nodone", 32'(done), 32'd0);
    end
    tick();
    check("t1_done",   32'(done),    32'd1);
    check("t1_id",     32'(done_id), 32'd0);
    check("t1_gnt_lo", 32'(gnt),     32'd0);

    // All requesting, all equal: rotating grants with one idle cycle between.
    do_reset();
    req = 4'b1111; w1 = 4'b1111; w2 = 4'b1111;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int j = 0; j < 5; j++) begin
      tick();
      check("t2_gnt", 32'(gnt), 32'(seq[j]));
      for (int i = 0; i < RUN_LEN - 1; i++) tick();
      tick();
      check("t2_done", 32'(done), 32'd1);
      check("t2_gap",  32'(gnt),  32'd0);
    end

    // Unequal every third sample: never a run of 4, so timeout on RUN edge 16.
    do_reset();
    req = 4'b0100;
    tick();
    for (int s = 0; s < TIMEOUT; s++) begin
      w1 = '0;
      w2 = (s % 3 == 2) ? 4'b0100 : 4'b0000;
      tick();
      if (s < TIMEOUT - 1) check("t3_early", 32'({done, timeout}), 32'd0);
    end
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_nodone",  32'(done),    32'd0);
    check("t3_id",      32'(done_id), 32'd2);

    // Run broken after 3 equal samples: counter restarts, done on RUN edge 8.
    do_reset();
    req = 4'b0010;
    tick();
    pat = '{1, 1, 1, 0, 1, 1, 1, 1};
    for (int s = 0; s < 8; s++) begin
      w1 = 4'b0000;
      w2 = pat[s] ? 4'b0000 : 4'b0010;
      tick();
      if (s < 7) check("t4_early", 32'(done), 32'd0);
    end
    check("t4_done", 32'(done),    32'd1);
    check("t4_id",   32'(done_id), 32'd1);

    // Abort by dropping req, then wrap from ptr=2 back to channel 0.
    do_reset();
    req = 4'b0010; w1 = '0; w2 = '0;
    tick();
    tick();
    req = 4'b0000;
    tick();
    check("t5_abort_gnt", 32'(gnt), 32'd0);
    check("t5_abort_pulse", 32'({done, timeout}), 32'd0);
    req = 4'b0011;
    tick();
    check("t5_wrap", 32'(gnt), 32'd1);

    // Asynchronous reset mid-RUN: outputs drop before the next edge.
    do_reset();
    req = 4'b0110; w1 = '0; w2 = '0;
    tick();
    tick();
    #2;
    Resetn = 1'b0;
    #1;
    check("t6_gnt",  32'(gnt),  32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_pulse", 32'({done, timeout}), 32'd0);
    model_reset();
    req = 4'b1000;
    @(negedge Clock);
    Resetn = 1'b1;
    tick();
    check("t6_first", 32'(gnt), 32'd8);

    // Randomized traffic: slowly toggling requests, pairs mostly equal.
    do_reset();
    for (int phase = 0; phase < 2; phase++) begin
      rate = (phase == 0) ? 8 : 3;
      for (int c = 0; c < 1500; c++) begin
        for (int b = 0; b < N; b++) begin
          if ($urandom_range(15) == 0) req[b] = ~req[b];
          flip[b] = ($urandom_range(rate - 1) == 0);
        end
        w1 = N'($urandom);
        w2 = w1 ^ flip;
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
